// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit path.
//   GMII_PRE / GMII_SFD : preamble and start-of-frame delimiter bytes
//   LEN_W               : width of the frame length (byte count) field
//   tx_state_t          : transmit framer state encoding
package gmii_pkg;

    localparam logic [7:0]  GMII_PRE = 8'h55;
    localparam logic [7:0]  GMII_SFD = 8'hD5;
    localparam int unsigned LEN_W    = 11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        IFG  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/gmii_tx_ctrl.sv
// GMII transmit framer. Waits for a complete frame announced by the frame
// length queue, emits preamble + SFD, streams exactly that many bytes out of
// the data FIFO and then holds TXEN low for the inter-frame gap.
//
// Ports:
//   TCLK        transmit clock; all logic on this clock
//   ARST        asynchronous active-high reset
//   FIFO_RDAT   data FIFO read data, valid one cycle after FIFO_REN
//   FIFO_REN    data FIFO pop strobe (combinational from state/counter)
//   FIFO_VALID  length queue non-empty (a complete frame is stored)
//   FIFO_RCNT   byte count of the head frame (show-ahead)
//   GMII_TXD    transmit data (registered)
//   GMII_TXEN   transmit enable (registered)
//   GMII_TXER   transmit error (registered)
//   TX_BUSY     high in every state except IDLE
//   TX_FRMCNT   transmitted frame count, wraps
module gmii_tx_ctrl
    import gmii_pkg::*;
#(
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned IFG_LEN = 12
) (
    input  logic             TCLK,
    input  logic             ARST,
    input  logic [7:0]       FIFO_RDAT,
    output logic             FIFO_REN,
    input  logic             FIFO_VALID,
    input  logic [LEN_W-1:0] FIFO_RCNT,
    output logic [7:0]       GMII_TXD,
    output logic             GMII_TXEN,
    output logic             GMII_TXER,
    output logic             TX_BUSY,
    output logic [15:0]      TX_FRMCNT
);

    localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);
    localparam logic [4:0] IFG_LAST = 5'(IFG_LEN - 1);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] len_cnt, len_nxt;   // bytes still to send in DATA
    logic [4:0]       ph_cnt, ph_nxt;     // shared PRE / IFG phase counter
    logic             zero_len, zero_nxt; // frame was announced with length 0
    logic [15:0]      frm_cnt, frm_nxt;
    logic [7:0]       txd_mux;
    logic             txen_mux;
    logic             txer_mux;

    always_comb begin
        state_nxt = state;
        len_nxt   = len_cnt;
        ph_nxt    = ph_cnt;
        zero_nxt  = zero_len;
        frm_nxt   = frm_cnt;
        FIFO_REN  = 1'b0;
        txd_mux   = '0;
        txen_mux  = 1'b0;
        txer_mux  = 1'b0;

        unique case (state)
            IDLE: begin
                if (FIFO_VALID) begin
                    // A zero length is illegal; send it as one flagged byte so
                    // the data FIFO still pops exactly once for this frame.
                    zero_nxt  = (FIFO_RCNT == '0);
                    len_nxt   = (FIFO_RCNT == '0) ? LEN_W'(1) : FIFO_RCNT;
                    ph_nxt    = '0;
                    state_nxt = PRE;
                end
            end
            PRE: begin
                txd_mux  = GMII_PRE;
                txen_mux = 1'b1;
                if (ph_cnt == PRE_LAST) begin
                    ph_nxt    = '0;
                    state_nxt = SFD;
                end else begin
                    ph_nxt = ph_cnt + 5'd1;
                end
            end
            SFD: begin
                // First pop here so byte 0 is on FIFO_RDAT in the first DATA cycle.
                txd_mux   = GMII_SFD;
                txen_mux  = 1'b1;
                FIFO_REN  = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                txd_mux  = FIFO_RDAT;
                txen_mux = 1'b1;
                txer_mux = zero_len;
                if (len_cnt == LEN_W'(1)) begin
                    ph_nxt    = '0;
                    frm_nxt   = frm_cnt + 16'd1;
                    state_nxt = IFG;
                end else begin
                    FIFO_REN = 1'b1;
                    len_nxt  = len_cnt - LEN_W'(1);
                end
            end
            IFG: begin
                if (ph_cnt == IFG_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    ph_nxt = ph_cnt + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge TCLK or posedge ARST) begin
        if (ARST) begin
            state     <= IDLE;
            len_cnt   <= '0;
            ph_cnt    <= '0;
            zero_len  <= 1'b0;
            frm_cnt   <= '0;
            GMII_TXD  <= '0;
            GMII_TXEN <= 1'b0;
            GMII_TXER <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_cnt   <= len_nxt;
            ph_cnt    <= ph_nxt;
            zero_len  <= zero_nxt;
            frm_cnt   <= frm_nxt;
            GMII_TXD  <= txd_mux;
            GMII_TXEN <= txen_mux;
            GMII_TXER <= txer_mux;
        end
    end

    assign TX_BUSY   = (state != IDLE);
    assign TX_FRMCNT = frm_cnt;

endmodule

// File: tb/tb_gmii_tx_ctrl.sv
// Directed testbench for gmii_tx_ctrl. A negedge-driven model plays the
// data FIFO and length queue and records the GMII stream; the main initial
// block queues frames and compares the recorded stream against its own
// expected bytes, lengths, gaps and counters.
module tb_gmii_tx_ctrl;

    logic        TCLK;
    logic        ARST;
    logic [7:0]  FIFO_RDAT;
    logic        FIFO_REN;
    logic        FIFO_VALID;
    logic [10:0] FIFO_RCNT;
    logic [7:0]  GMII_TXD;
    logic        GMII_TXEN;
    logic        GMII_TXER;
    logic        TX_BUSY;
    logic [15:0] TX_FRMCNT;

    gmii_tx_ctrl #(.PRE_LEN(7), .IFG_LEN(12)) dut (
        .TCLK       (TCLK),
        .ARST       (ARST),
        .FIFO_RDAT  (FIFO_RDAT),
        .FIFO_REN   (FIFO_REN),
        .FIFO_VALID (FIFO_VALID),
        .FIFO_RCNT  (FIFO_RCNT),
        .GMII_TXD   (GMII_TXD),
        .GMII_TXEN  (GMII_TXEN),
        .GMII_TXER  (GMII_TXER),
        .TX_BUSY    (TX_BUSY),
        .TX_FRMCNT  (TX_FRMCNT)
    );

    initial TCLK = 1'b0;
    always #4 TCLK = ~TCLK;

    // Frame table: written by the main block, read by the FIFO model.
    logic [10:0] frm_len [0:31];
    logic [4:0]  frm_wr;
    logic [4:0]  frm_rd;

    assign FIFO_VALID = (frm_wr != frm_rd);
    assign FIFO_RCNT  = frm_len[frm_rd];

    function automatic logic [7:0] gen_byte(input int f, input int k);
        return 8'((f * 37 + k * 13 + 5) & 255);
    endfunction

    function automatic int eff_len(input logic [10:0] l);
        return (l == 11'd0) ? 1 : int'(l);
    endfunction

    // FIFO model + stream monitor (owns everything it writes)
    logic [7:0] txd_q[$];
    int         runs[$];
    int         gaps[$];
    int         run_len, gap_cnt, er_cnt, ren_cnt, byte_k;
    logic       prev_en, seen, pend;
    logic [7:0] pend_byte;

    initial begin
        frm_rd = '0; byte_k = 0; pend = 1'b0; pend_byte = '0; FIFO_RDAT = '0;
        run_len = 0; gap_cnt = 0; er_cnt = 0; ren_cnt = 0; prev_en = 1'b0; seen = 1'b0;
    end

    always @(negedge TCLK) begin
        if (ARST) begin
            frm_rd    = frm_wr;
            byte_k    = 0;
            pend      = 1'b0;
            FIFO_RDAT = '0;
            txd_q.delete();
            runs.delete();
            gaps.delete();
            run_len   = 0;
            gap_cnt   = 0;
            prev_en   = 1'b0;
            seen      = 1'b0;
        end else begin
            if (pend) FIFO_RDAT = pend_byte;
            pend = FIFO_REN;
            if (FIFO_REN) begin
                pend_byte = gen_byte(int'(frm_rd), byte_k);
                ren_cnt++;
                byte_k++;
                if (byte_k == eff_len(frm_len[frm_rd])) begin
                    byte_k = 0;
                    frm_rd = frm_rd + 5'd1;
                end
            end
            if (GMII_TXEN) begin
                if (!prev_en && seen) gaps.push_back(gap_cnt);
                run_len++;
                txd_q.push_back(GMII_TXD);
                if (GMII_TXER) er_cnt++;
            end else begin
                if (prev_en) begin
                    runs.push_back(run_len);
                    run_len = 0;
                    seen    = 1'b1;
                    gap_cnt = 0;
                end
                gap_cnt++;
            end
            prev_en = GMII_TXEN;
        end
    end

    // Checking
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         chk_pos = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [10:0] len);
        frm_len[frm_wr] = len;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < eff_len(len); k++) exp_q.push_back(gen_byte(int'(frm_wr), k));
        frm_wr = frm_wr + 5'd1;
    endtask

    task automatic check_stream(input string tag);
        int nbad  = 0;
        int first = -1;
        check({tag, "_bytes"}, txd_q.size(), exp_q.size());
        for (int i = chk_pos; i < exp_q.size() && i < txd_q.size(); i++) begin
            if (txd_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        vectors++;
        assert (nbad == 0) else begin
            miscompares++;
            $error("FAIL %s_data: %0d bytes differ, first at %0d observed %0h expected %0h",
                   tag, nbad, first, txd_q[first], exp_q[first]);
        end
        chk_pos = exp_q.size();
    endtask

    task automatic wait_runs(input string tag, input int target, input int budget);
        int t = 0;
        while (runs.size() < target && t < budget) begin
            @(negedge TCLK); #2;
            t++;
        end
        check({tag, "_done"}, runs.size(), target);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (TX_BUSY && t < budget) begin
            @(negedge TCLK); #2;
            t++;
        end
        check("idle", TX_BUSY, 1'b0);
    endtask

    int ren0, er0, lat;

    initial begin
        frm_wr = '0;
        for (int i = 0; i < 32; i++) frm_len[i] = '0;
        ARST = 1'b1;
        #1;
        check("rst_ren",    FIFO_REN,  1'b0);
        check("rst_txd",    GMII_TXD,  8'h00);
        check("rst_txen",   GMII_TXEN, 1'b0);
        check("rst_txer",   GMII_TXER, 1'b0);
        check("rst_busy",   TX_BUSY,   1'b0);
        check("rst_frmcnt", TX_FRMCNT, 16'h0000);
        repeat (3) @(negedge TCLK);
        #2 ARST = 1'b0;
        repeat (2) @(negedge TCLK);
        #2;

        // Single 64-byte frame, with launch latency
        ren0 = ren_cnt;
        push_frame(11'd64);
        lat = 0;
        while (!GMII_TXEN && lat < 10) begin
            @(negedge TCLK); #2;
            lat++;
        end
        check("latency", lat, 2);
        wait_runs("f64", 1, 500);
        check("f64_txen_len", runs[0], 72);
        check("f64_ren", ren_cnt - ren0, 64);
        check("f64_frmcnt", TX_FRMCNT, 16'd1);
        check_stream("f64");
        wait_idle(100);

        // Back-to-back 60 + 1514
        ren0 = ren_cnt;
        push_frame(11'd60);
        push_frame(11'd1514);
        wait_runs("b2b", 3, 3000);
        check("b2b_len0", runs[1], 68);
        check("b2b_len1", runs[2], 1522);
        check("b2b_gap", gaps[gaps.size() - 1], 13);
        check("b2b_ren", ren_cnt - ren0, 1574);
        check("b2b_frmcnt", TX_FRMCNT, 16'd3);
        check_stream("b2b");
        wait_idle(100);

        // Minimum length
        ren0 = ren_cnt;
        push_frame(11'd1);
        wait_runs("len1", 4, 200);
        check("len1_txen_len", runs[3], 9);
        check("len1_ren", ren_cnt - ren0, 1);
        check_stream("len1");
        wait_idle(100);

        // Maximum length
        ren0 = ren_cnt;
        push_frame(11'd2047);
        wait_runs("len2047", 5, 5000);
        check("len2047_txen_len", runs[4], 2055);
        check("len2047_ren", ren_cnt - ren0, 2047);
        check_stream("len2047");
        wait_idle(100);

        // Illegal zero length
        ren0 = ren_cnt;
        er0  = er_cnt;
        push_frame(11'd0);
        wait_runs("len0", 6, 200);
        check("len0_txen_len", runs[5], 9);
        check("len0_ren", ren_cnt - ren0, 1);
        check("len0_txer", er_cnt - er0, 1);
        check("len0_frmcnt", TX_FRMCNT, 16'd6);
        check_stream("len0");
        wait_idle(100);

        // Reset in the middle of a 100-byte frame
        push_frame(11'd100);
        lat = 0;
        while (txd_q.size() < chk_pos + 38 && lat < 500) begin
            @(negedge TCLK); #2;
            lat++;
        end
        check("abort_reached", GMII_TXEN, 1'b1);
        #1 ARST = 1'b1;
        #1;
        check("abort_txen",   GMII_TXEN, 1'b0);
        check("abort_txd",    GMII_TXD,  8'h00);
        check("abort_txer",   GMII_TXER, 1'b0);
        check("abort_ren",    FIFO_REN,  1'b0);
        check("abort_busy",   TX_BUSY,   1'b0);
        check("abort_frmcnt", TX_FRMCNT, 16'h0000);
        @(negedge TCLK);
        #2 ARST = 1'b0;
        exp_q.delete();
        chk_pos = 0;
        @(negedge TCLK); #2;
        ren0 = ren_cnt;
        push_frame(11'd50);
        wait_runs("post_rst", 1, 300);
        check("post_rst_txen_len", runs[0], 58);
        check("post_rst_ren", ren_cnt - ren0, 50);
        check("post_rst_frmcnt", TX_FRMCNT, 16'd1);
        check_stream("post_rst");
        wait_idle(100);

        // Frame counter wrap
        force dut.frm_cnt = 16'hFFFF;
        repeat (2) @(negedge TCLK);
        release dut.frm_cnt;
        @(negedge TCLK); #2;
        check("wrap_preload", TX_FRMCNT, 16'hFFFF);
        push_frame(11'd1);
        wait_runs("wrap", 2, 200);
        check("wrap_frmcnt", TX_FRMCNT, 16'h0000);
        check_stream("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
